conv_rr_scheduler: RTL

- Shares one ConvUnit between N_REQ requesters using round-robin arbitration.
- Each requester presents an input vector and a kernel over valid/ready. The scheduler forwards one granted request at a time to the ConvUnit input port.
- It records the requester index of every issued job in an in-order tag FIFO. Each ConvUnit result is routed back to the requester whose tag is at the FIFO head.
- It sits between the requesters (data generators / upstream engines) and the ConvUnit.

---
 rtl/conv_rr_if.sv | 49 ++++
 rtl/conv_rr_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/conv_rr_if.sv
// Bundle of the requester-side and ConvUnit-side handshake buses of the
// round-robin ConvUnit scheduler.
//
// Handshake rule for every valid/ready pair here: a transfer happens on the
// rising clk edge where valid and ready are both 1. Once valid is raised, it
// and its payload stay stable until that edge. valid never depends on ready.
interface conv_rr_if #(
   parameter int N_REQ     = 4,
   parameter int DW        = 64,
   parameter int KW        = 64,
   parameter int RW        = 128,
   parameter int TAG_DEPTH = 4,
   parameter int OW        = $clog2(TAG_DEPTH + 1)
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ*KW-1:0] req_kernel;
   logic [N_REQ-1:0]    rsp_valid;
   logic [N_REQ-1:0]    rsp_ready;
   logic [RW-1:0]       rsp_data;
   logic                cu_in_valid;
   logic                cu_in_ready;
   logic [DW-1:0]       cu_in_data;
   logic [KW-1:0]       cu_kernel;
   logic [RW-1:0]       cu_result;
   logic                cu_out_valid;
   logic                cu_out_ready;
   logic [OW-1:0]       outstanding;
   logic                err;

   // Scheduler side.
   modport master (
      input  req_valid, req_data, req_kernel, rsp_ready,
             cu_in_ready, cu_result, cu_out_valid,
      output req_ready, rsp_valid, rsp_data,
             cu_in_valid, cu_in_data, cu_kernel, cu_out_ready,
             outstanding, err
   );

   // Environment side: the requesters and the ConvUnit.
   modport slave (
      output req_valid, req_data, req_kernel, rsp_ready,
             cu_in_ready, cu_result, cu_out_valid,
      input  req_ready, rsp_valid, rsp_data,
             cu_in_valid, cu_in_data, cu_kernel, cu_out_ready,
             outstanding, err
   );
endinterface

// File: rtl/conv_rr_scheduler.sv
// Round-robin scheduler sharing one ConvUnit between N_REQ requesters.
// One granted job is forwarded at a time. The requester index of every issued
// job goes into an in-order tag FIFO, and each ConvUnit result is routed back
// to the requester whose tag is at the FIFO head.
module conv_rr_scheduler #(
   parameter int N_REQ     = 4,
   parameter int DW        = 64,
   parameter int KW        = 64,
   parameter int RW        = 128,
   parameter int TAG_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rstn,
   conv_rr_if.master sched_if,
   output logic     state_o
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int OW = $clog2(TAG_DEPTH + 1);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          err_q, err_d;
   logic [IW-1:0] tag_mem_q [TAG_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] count_q, count_d;

   logic          fifo_empty, fifo_full;
   logic          push, pop;
   logic          any_req;
   logic [IW-1:0] rr_pick;
   logic [IW-1:0] head;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == OW'(TAG_DEPTH));
   assign head       = tag_mem_q[rd_ptr_q];
   assign state_o    = state_q;

   assign sched_if.rsp_data    = sched_if.cu_result;
   assign sched_if.outstanding = count_q;
   assign sched_if.err         = err_q;

   // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      rr_pick = rr_ptr_q;
      any_req = 1'b0;
      // Walk downwards so the candidate closest to rr_ptr is written last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (sched_if.req_valid[idx]) begin
            rr_pick = IW'(idx);
            any_req = 1'b1;
         end
      end
   end

   // Result routing to the requester at the head of the tag FIFO.
   always_comb begin
      sched_if.rsp_valid    = '0;
      sched_if.cu_out_ready = 1'b0;
      if (!fifo_empty) begin
         sched_if.rsp_valid[head] = sched_if.cu_out_valid;
         sched_if.cu_out_ready    = sched_if.rsp_ready[head];
      end
      pop = sched_if.cu_out_valid & sched_if.cu_out_ready;
   end

   // FSM next state and issue-side outputs.
   always_comb begin
      state_d              = state_q;
      grant_d              = grant_q;
      rr_ptr_d             = rr_ptr_q;
      push                 = 1'b0;
      sched_if.cu_in_valid = 1'b0;
      sched_if.cu_in_data  = '0;
      sched_if.cu_kernel   = '0;
      sched_if.req_ready   = '0;
      unique case (state_q)
         IDLE: begin
            // A pop in this same cycle frees a slot in time for the push.
            if (any_req && (!fifo_full || pop)) begin
               grant_d = rr_pick;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            sched_if.cu_in_valid        = 1'b1;
            sched_if.cu_in_data         = sched_if.req_data[int'(grant_q)*DW +: DW];
            sched_if.cu_kernel          = sched_if.req_kernel[int'(grant_q)*KW +: KW];
            sched_if.req_ready[grant_q] = sched_if.cu_in_ready;
            if (sched_if.cu_in_ready) begin
               push     = 1'b1;
               rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky protocol error: a dropped request while issuing, or a result with no tag.
   always_comb begin
      err_d = err_q;
      if (state_q == ISSUE && !sched_if.req_valid[grant_q]) err_d = 1'b1;
      if (sched_if.cu_out_valid && fifo_empty)              err_d = 1'b1;
   end

   // Tag FIFO pointer and occupancy next state.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   // Tag FIFO storage and pointers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) tag_mem_q[wr_ptr_q] <= grant_q;
      end
   end
endmodule
